// File: rtl/xdsc_pkg.sv
// Purpose : shared constants and the 32-step PRBS31 (x^31+x^28+1) advance function
// Latency : n/a (package; function is purely combinational)
// Backpressure: n/a
// Contents: tap constants, default seed, lfsr_adv32(state) -> {next_state[30:0], keystream[31:0]}
package xdsc_pkg;

  localparam int          XDSC_DW           = 32;
  localparam int          XDSC_LFSR_W       = 31;
  // Polynomial exponents; the tapped state bits are exponent-1.
  localparam int          PRBS31_TAP_A      = 31;
  localparam int          PRBS31_TAP_B      = 28;
  localparam logic [30:0] XDSC_DEFAULT_SEED = 31'h7FFF_FFFF;

  // Advance a Fibonacci PRBS31 by 32 steps. Step bit i lands in keystream[i],
  // so keystream bit 0 is the first bit produced from the given state.
  function automatic logic [62:0] lfsr_adv32(input logic [30:0] state);
    logic [30:0] s;
    logic [31:0] k;
    logic        b;
    s = state;
    k = '0;
    for (int i = 0; i < 32; i++) begin
      b    = s[PRBS31_TAP_A-1] ^ s[PRBS31_TAP_B-1];
      k[i] = b;
      s    = {s[29:0], b};
    end
    return {s, k};
  endfunction

endpackage

// File: rtl/prbs31_step32.sv
// Purpose : combinational 32-step unroll of the PRBS31 LFSR
// Latency : 0 cycles (pure combinational)
// Backpressure: none; no handshake, output follows base
// Ports   : base (31) in -> keystream (32) out, next_state (31) out
module prbs31_step32
  import xdsc_pkg::*;
(
  input  logic [30:0] base,
  output logic [31:0] keystream,
  output logic [30:0] next_state
);

  assign {next_state, keystream} = lfsr_adv32(base);

endmodule

// File: rtl/xor_descrambler_32.sv
// Purpose : receive-side additive PRBS31 descrambler, 32-bit words, reseeds on SOF
// Latency : 1 cycle accept -> out_valid; full throughput (1 word/clk) when out_ready=1
// Backpressure: in_ready = !out_valid || out_ready; output word/sof hold while stalled
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/in_data/in_sof;
//           out_valid/out_ready/out_data/out_sof; lfsr_state (debug)
// Option  : define XDSC_BYPASS_EN to add a 'bypass' input (raw pass-through, keystream still advances)
module xor_descrambler_32
  import xdsc_pkg::*;
#(
  parameter logic [30:0] SEED = XDSC_DEFAULT_SEED,
  parameter int          DW   = XDSC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
`ifdef XDSC_BYPASS_EN
  input  logic          bypass,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic [30:0]   lfsr_state
);

  if (DW != 32) begin : g_dw_check
    $error("xor_descrambler_32: DW must be 32");
  end
  if (SEED == 31'd0) begin : g_seed_check
    $error("xor_descrambler_32: SEED must be nonzero");
  end

  logic          accept;
  logic [30:0]   lfsr_q;
  logic [30:0]   base;
  logic [30:0]   lfsr_nxt;
  logic [31:0]   keystream;
  logic [DW-1:0] data_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // An SOF word restarts the keystream from SEED for that very word.
  assign base = in_sof ? SEED : lfsr_q;

  prbs31_step32 u_step (
    .base       (base),
    .keystream  (keystream),
    .next_state (lfsr_nxt)
  );

`ifdef XDSC_BYPASS_EN
  assign data_nxt = bypass ? in_data : (in_data ^ keystream);
`else
  assign data_nxt = in_data ^ keystream;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      lfsr_q    <= SEED;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= data_nxt;
        out_sof   <= in_sof;
        // Keystream only moves on accepted words so stalls/bubbles keep alignment.
        lfsr_q    <= lfsr_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign lfsr_state = lfsr_q;

endmodule

// File: doc/xor_descrambler_32.md
Name: xor_descrambler_32

Overview:
- Receive-side additive descrambler for 32-bit words. Each word is XORed with a PRBS31 keystream; this undoes the transmit-side scrambler, which XORs with the same keystream.
- Sits between the link word deserializer and the downstream consumer.
- Valid/ready in and out, one registered output stage. The LFSR reseeds on every start-of-frame word.

Parameters:
- SEED, 31'h7FFF_FFFF, LFSR value loaded at reset and on each accepted SOF word. Must be nonzero.
- DW, 32, data word width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  32  scrambled word.
- in_sof  in  1  first word of frame; qualified by in_valid.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream ready.
- out_data  out  32  descrambled word.
- out_sof  out  1  SOF flag aligned with out_data.
- lfsr_state  out  31  current LFSR state (debug).

Behaviour:
- Reset:
  - One clock. Asynchronous active-low reset on rst_n.
  - Reset state: out_valid=0, out_data=0, out_sof=0, lfsr=SEED.
- LFSR:
  - Fibonacci, polynomial x^31+x^28+1, state s[30:0].
  - One step: bit = s[30]^s[27]; s <= {s[29:0], bit}.
  - Keystream K for a word = 32 consecutive step bits. Step bit i XORs data bit i, so bit 0 comes first.
- Accept (in_valid && in_ready):
  - Seed base: if in_sof=1, start from SEED; otherwise start from the current lfsr.
  - Compute K from that base.
  - Register out_data = in_data ^ K and out_sof = in_sof.
  - lfsr <= base advanced 32 steps.
  - Latency: exactly 1 cycle from accept to out_valid.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - out_valid sets on accept. It clears when out_ready && !accept.
  - Simultaneous output pop and input accept in the same cycle is full throughput: 1 word per clock.
  - While out_valid && !out_ready, out_data and out_sof hold stable and in_ready=0.
  - in_data and in_sof are ignored when in_valid=0.
- LFSR update rule: lfsr changes only on accept. Stalls and bubbles do not advance the keystream.
- Boundary cases:
  - SOF on a back-to-back word mid-frame reseeds immediately; the new keystream is used for that word.
  - Consecutive SOF words each produce K0 = 32'h7000_0000 when SEED is the default.
  - Reset asserted mid-stream drops the pending output word and restores SEED.
  - LFSR lockup at 0 is unreachable, because SEED is nonzero and the map is invertible.

Optional Feature:
- Macro: XDSC_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), sampled on accept.
  - When bypass=1, out_data = in_data unmodified. The LFSR still advances and reseeds exactly as in normal mode, so keystream alignment is preserved when bypass deasserts.
- Undefined:
  - No bypass port exists.
  - Data is always descrambled.

Decomposition:
- Shared package xdsc_pkg holds:
  - PRBS31 tap constants (31, 28).
  - Default seed constant.
  - Function lfsr_adv32(state) returning {next_state, keystream}. The testbench model uses the same function.
- One sub-module, prbs31_step32: purely combinational 32-step unroll. It is instantiated once and fed by the base-select mux.
- The top level holds the mux, the registers and the handshake.

Test Plan:
- Reset, then send 1 word: in_data=0, in_sof=1, out_ready=1 -> out_valid next cycle, out_data=32'h7000_0000, out_sof=1, lfsr_state=SEED advanced 32 steps.
- Scramble 8 random words with the package model, send them back-to-back with SOF on word 0 -> 8 consecutive output cycles; out_data equals the originals with no bubble.
- Hold out_ready=0 for 5 cycles after the first word -> in_ready=0, out_data stable, lfsr_state unchanged. Release -> the stream resumes with the correct words.
- Assert SOF on word 3 of a 6-word frame -> word 3 equals in_data^32'h7000_0000 (K0), and words 4-5 use the continued keystream from the reseed.
- Pull rst_n low asynchronously between clock edges while out_valid=1 -> out_valid, out_data and out_sof go to 0 immediately and lfsr_state=SEED. Next SOF word decodes correctly.
- With XDSC_BYPASS_EN defined, set bypass=1 on words 1-2 of 4 -> those words pass raw, and words 3-4 decode correctly.
